fpreg_wb_arbiter: RTL and testbench
===================================

FPREG_WB_ARBITER -- requirements
Module: fpreg_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Clk  input  1  clock; all state changes on the positive edge.
REQ-003 Reset  input  1  asynchronous active-high reset.
REQ-004 AluValid  input  1  FP ALU result offered.
REQ-005 AluReady  output  1  ALU result accepted on this edge when AluValid is also high.
REQ-006 AluRegister  input  5  destination FP register of the ALU result.
REQ-007 AluData  input  32  ALU result (IEEE-754 single).
REQ-008 LoadValid  input  1  load (lwc1) data offered.
REQ-009 LoadReady  output  1  load data accepted on this edge when LoadValid is also high.
REQ-010 LoadRegister  input  5  destination FP register of the load.
REQ-011 LoadData  input  32  load data.
REQ-012 WriteData  output  32  drives the FP register file WriteData.
REQ-013 WriteRegister  output  5  drives the FP register file WriteRegister.
REQ-014 RegWrite  output  1  drives the FP register file RegWrite.
REQ-015 PendingMask  output  32  bit n high while any write to register n is held or presented.

Function
REQ-016 Each requester SHALL own a one-entry holding register of {valid, register, data}.
REQ-017 A transfer SHALL occur on an edge where Valid and Ready are both high; the entry is captured at that edge.
REQ-018 Each cycle the arbiter SHALL grant at most one full holding register; the grant is combinational from the full flags and the priority state.
REQ-019 Ready SHALL equal (holding register empty) OR (that requester is granted this cycle), which sustains one transfer per cycle per requester.
REQ-020 On an edge with a grant, the granted entry SHALL move to the output stage (WriteData, WriteRegister) and be cleared from its holding register unless refilled on the same edge.
REQ-021 RegWrite SHALL be high for exactly one cycle per granted entry.
REQ-022 Latency: accepted at edge N, uncontended, RegWrite high after edge N+1; register file updated at edge N+2.
REQ-023 A granted entry with register 0 SHALL consume the grant, and RegWrite SHALL stay low, because register 0 is constant 1.0 (0x3f800000).
REQ-024 With no grant, RegWrite SHALL be 0; WriteData and WriteRegister SHALL hold their last values.
REQ-025 PendingMask SHALL be the OR of one-hot decodes of the valid holding entries and the output stage; bit 0 SHALL always be 0.
REQ-026 When both entries target the same register, writes SHALL reach the register file in grant order, so the later grant wins.
REQ-027 Valid deasserted without a handshake SHALL leave the holding register unchanged; a captured entry SHALL never be dropped or duplicated.

Reset
REQ-028 Reset asserted SHALL immediately clear both holding valids, RegWrite, and PendingMask; WriteData and WriteRegister SHALL be 0; the priority state SHALL select Load.
REQ-029 Reset asserted mid-operation SHALL discard all held entries with no RegWrite pulse; AluReady and LoadReady SHALL be 1 while Reset is high.
REQ-030 The first edge after Reset deasserts SHALL be able to accept entries.

Configuration
REQ-031 With FPREG_WB_ROUNDROBIN_EN defined: when both entries are full, the grant SHALL alternate, and the last-granted requester SHALL lose the next tie; the priority state updates only on a tie.
REQ-032 Without FPREG_WB_ROUNDROBIN_EN: fixed priority, and Load SHALL always win a tie.

Verification
REQ-033 Single ALU write: AluValid=1, AluRegister=5, AluData=0x40490FDB at edge 1 -> RegWrite=1, WriteRegister=5, WriteData=0x40490FDB after edge 2; PendingMask=0x20 after edges 1 and 2, 0 after edge 3.
REQ-034 Register 0 write: LoadValid=1, LoadRegister=0, LoadData=0x12345678 -> LoadReady=1, no RegWrite pulse, PendingMask bit 0 stays 0.
REQ-035 Tie with macro defined: both Valid held high for 4 edges to registers 3 (Load) and 7 (ALU) -> WriteRegister sequence 3,7,3,7; without macro -> 3,3,3,3 with AluReady low after its first capture.
REQ-036 Same-destination tie: Load writes 0x3F800000 and ALU writes 0x40000000, both to register 9 -> two RegWrite pulses in grant order; the register file finally holds the second granted value.
REQ-037 Reset mid-operation: both holding registers full, Reset pulsed asynchronously between edges -> RegWrite and PendingMask go 0 before the next edge, and no further writes occur.

Source files
------------

// File: rtl/fpreg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fpreg_wb_arbiter
// Write-back arbiter for the FP register file. Two requesters share the single
// register-file write port: the FP ALU and the FP load path (lwc1). Each one
// owns a one-entry holding register, and a registered output stage drives the
// register file.
//
// Ports
//   Clk            clock; all state changes on the rising edge
//   Reset          asynchronous active-high reset
//   AluValid       ALU result offered
//   AluReady       ALU result taken on this edge when AluValid is also high
//   AluRegister    [4:0]  destination register of the ALU result
//   AluData        [31:0] ALU result
//   LoadValid      load data offered
//   LoadReady      load data taken on this edge when LoadValid is also high
//   LoadRegister   [4:0]  destination register of the load
//   LoadData       [31:0] load data
//   WriteData      [31:0] register file write data
//   WriteRegister  [4:0]  register file write address
//   RegWrite       register file write enable, one cycle per granted entry
//   PendingMask    [31:0] bit n set while a write to register n is held or
//                         presented to the register file
//
// Build option
//   FPREG_WB_ROUNDROBIN_EN  defined: ties alternate between the requesters,
//                           and the last-granted one loses the next tie.
//                           undefined: fixed priority, Load always wins a tie.
// ---------------------------------------------------------------------------
module fpreg_wb_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AluValid,
  output logic        AluReady,
  input  logic [4:0]  AluRegister,
  input  logic [31:0] AluData,
  input  logic        LoadValid,
  output logic        LoadReady,
  input  logic [4:0]  LoadRegister,
  input  logic [31:0] LoadData,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite,
  output logic [31:0] PendingMask
);

  // One-hot decode of a register number.
  function automatic logic [31:0] onehot32(input logic [4:0] idx);
    logic [31:0] v;
    v = 32'd0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic        load_full_r;
  logic [4:0]  load_reg_r;
  logic [31:0] load_data_r;
  logic        alu_full_r;
  logic [4:0]  alu_reg_r;
  logic [31:0] alu_data_r;
  logic        reg_write_r;
  logic [4:0]  write_reg_r;
  logic [31:0] write_data_r;
  logic        grant_load_s;
  logic        grant_alu_s;
  logic [31:0] pending_s;

`ifdef FPREG_WB_ROUNDROBIN_EN
  // Set when the ALU wins the next tie; flips only when both entries are full.
  logic        prio_alu_r;

  // Priority state: the requester granted on a tie loses the next tie.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      prio_alu_r <= 1'b0;
    end else if (load_full_r && alu_full_r) begin
      prio_alu_r <= grant_load_s;
    end else begin
      prio_alu_r <= prio_alu_r;
    end
  end
`endif

  // Grant selection from the full flags and the priority state.
  always_comb begin
    grant_load_s = 1'b0;
    grant_alu_s  = 1'b0;
    if (load_full_r && alu_full_r) begin
`ifdef FPREG_WB_ROUNDROBIN_EN
      if (prio_alu_r) begin
        grant_alu_s = 1'b1;
      end else begin
        grant_load_s = 1'b1;
      end
`else
      grant_load_s = 1'b1;
`endif
    end else if (load_full_r) begin
      grant_load_s = 1'b1;
    end else if (alu_full_r) begin
      grant_alu_s = 1'b1;
    end else begin
      grant_load_s = 1'b0;
      grant_alu_s  = 1'b0;
    end
  end

  // A granted entry leaves on this edge, so its slot can be refilled at once.
  assign LoadReady = ~load_full_r | grant_load_s;
  assign AluReady  = ~alu_full_r  | grant_alu_s;

  // Load holding register: a refill on the grant edge takes precedence over the clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      load_full_r <= 1'b0;
      load_reg_r  <= 5'd0;
      load_data_r <= 32'd0;
    end else if (LoadValid && LoadReady) begin
      load_full_r <= 1'b1;
      load_reg_r  <= LoadRegister;
      load_data_r <= LoadData;
    end else if (grant_load_s) begin
      load_full_r <= 1'b0;
    end else begin
      load_full_r <= load_full_r;
    end
  end

  // ALU holding register: a refill on the grant edge takes precedence over the clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alu_full_r <= 1'b0;
      alu_reg_r  <= 5'd0;
      alu_data_r <= 32'd0;
    end else if (AluValid && AluReady) begin
      alu_full_r <= 1'b1;
      alu_reg_r  <= AluRegister;
      alu_data_r <= AluData;
    end else if (grant_alu_s) begin
      alu_full_r <= 1'b0;
    end else begin
      alu_full_r <= alu_full_r;
    end
  end

  // Output stage: register 0 is hardwired to 1.0, so its grant is consumed silently.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      reg_write_r  <= 1'b0;
      write_reg_r  <= 5'd0;
      write_data_r <= 32'd0;
    end else if (grant_load_s) begin
      reg_write_r  <= (load_reg_r != 5'd0);
      write_reg_r  <= load_reg_r;
      write_data_r <= load_data_r;
    end else if (grant_alu_s) begin
      reg_write_r  <= (alu_reg_r != 5'd0);
      write_reg_r  <= alu_reg_r;
      write_data_r <= alu_data_r;
    end else begin
      reg_write_r  <= 1'b0;
    end
  end

  // Pending destinations: both holding entries plus the write being presented.
  always_comb begin
    pending_s = 32'd0;
    if (load_full_r) begin
      pending_s = pending_s | onehot32(load_reg_r);
    end else begin
      pending_s = pending_s;
    end
    if (alu_full_r) begin
      pending_s = pending_s | onehot32(alu_reg_r);
    end else begin
      pending_s = pending_s;
    end
    if (reg_write_r) begin
      pending_s = pending_s | onehot32(write_reg_r);
    end else begin
      pending_s = pending_s;
    end
    pending_s[0] = 1'b0;
  end

  assign RegWrite      = reg_write_r;
  assign WriteRegister = write_reg_r;
  assign WriteData     = write_data_r;
  assign PendingMask   = pending_s;

endmodule

// File: tb/tb_fpreg_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpreg_wb_arbiter
// Directed self-checking bench for fpreg_wb_arbiter. Inputs change 1 ns after
// the rising edge, and outputs are checked at that point as well. Expected
// values are hand-computed. The tie expectations follow the
// FPREG_WB_ROUNDROBIN_EN build option.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fpreg_wb_arbiter;

  logic        Clk;
  logic        Reset;
  logic        AluValid;
  logic        AluReady;
  logic [4:0]  AluRegister;
  logic [31:0] AluData;
  logic        LoadValid;
  logic        LoadReady;
  logic [4:0]  LoadRegister;
  logic [31:0] LoadData;
  logic [31:0] WriteData;
  logic [4:0]  WriteRegister;
  logic        RegWrite;
  logic [31:0] PendingMask;

  int checks;
  int errors;

  fpreg_wb_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReady(AluReady),
    .AluRegister(AluRegister), .AluData(AluData),
    .LoadValid(LoadValid), .LoadReady(LoadReady),
    .LoadRegister(LoadRegister), .LoadData(LoadData),
    .WriteData(WriteData), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite), .PendingMask(PendingMask)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    #2;
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== 38'd0) begin
      errors++;
      $display("FAIL reset_out got %0b/%0d/%h want 0/0/0", RegWrite, WriteRegister, WriteData);
    end
    checks++;
    if ({AluReady, LoadReady, PendingMask} !== {1'b1, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_ready got %0b/%0b/%h want 1/1/0", AluReady, LoadReady, PendingMask);
    end
    step();
    Reset = 1'b0;
  endtask

  task automatic test_single_alu();
    AluValid = 1'b1; AluRegister = 5'd5; AluData = 32'h40490FDB;
    checks++;
    if (AluReady !== 1'b1) begin
      errors++; $display("FAIL alu_ready got %0b want 1", AluReady);
    end
    step();
    AluValid = 1'b0;
    checks++;
    if ({RegWrite, PendingMask} !== {1'b0, 32'h20}) begin
      errors++; $display("FAIL alu_e1 got %0b/%h want 0/00000020", RegWrite, PendingMask);
    end
    step();
    checks++;
    if ({RegWrite, WriteRegister, WriteData, PendingMask} !== {1'b1, 5'd5, 32'h40490FDB, 32'h20}) begin
      errors++;
      $display("FAIL alu_e2 got %0b/%0d/%h/%h want 1/5/40490fdb/00000020", RegWrite, WriteRegister, WriteData, PendingMask);
    end
    step();
    checks++;
    if ({RegWrite, WriteRegister, WriteData, PendingMask} !== {1'b0, 5'd5, 32'h40490FDB, 32'h0}) begin
      errors++;
      $display("FAIL alu_e3 got %0b/%0d/%h/%h want 0/5/40490fdb/0", RegWrite, WriteRegister, WriteData, PendingMask);
    end
  endtask

  task automatic test_reg0();
    LoadValid = 1'b1; LoadRegister = 5'd0; LoadData = 32'h12345678;
    checks++;
    if (LoadReady !== 1'b1) begin
      errors++; $display("FAIL reg0_ready got %0b want 1", LoadReady);
    end
    step();
    LoadValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({RegWrite, PendingMask} !== {1'b0, 32'h0}) begin
        errors++; $display("FAIL reg0_e%0d got %0b/%h want 0/0", i + 1, RegWrite, PendingMask);
      end
      step();
    end
  endtask

  task automatic test_tie();
    logic [4:0] exp_reg [4];
    logic       exp_ardy [4];
`ifdef FPREG_WB_ROUNDROBIN_EN
    exp_reg  = '{5'd3, 5'd7, 5'd3, 5'd7};
    exp_ardy = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_reg  = '{5'd3, 5'd3, 5'd3, 5'd3};
    exp_ardy = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    LoadValid = 1'b1; LoadRegister = 5'd3; LoadData = 32'h33333333;
    AluValid  = 1'b1; AluRegister  = 5'd7; AluData  = 32'h77777777;
    step();
    checks++;
    if ({PendingMask, AluReady, LoadReady, RegWrite} !== {32'h88, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tie_e1 got %h/%0b/%0b/%0b want 00000088/0/1/0", PendingMask, AluReady, LoadReady, RegWrite);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 3) begin
        LoadValid = 1'b0; AluValid = 1'b0;
      end
      checks++;
      if ({RegWrite, WriteRegister, AluReady} !== {1'b1, exp_reg[k], exp_ardy[k]}) begin
        errors++;
        $display("FAIL tie_w%0d got %0b/%0d/%0b want 1/%0d/%0b", k, RegWrite, WriteRegister, AluReady, exp_reg[k], exp_ardy[k]);
      end
    end
    // Drain: both entries still held; Load wins the remaining tie in either mode.
    step();
    checks++;
    if ({RegWrite, WriteRegister} !== {1'b1, 5'd3}) begin
      errors++; $display("FAIL tie_d1 got %0b/%0d want 1/3", RegWrite, WriteRegister);
    end
    step();
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd7, 32'h77777777}) begin
      errors++; $display("FAIL tie_d2 got %0b/%0d/%h want 1/7/77777777", RegWrite, WriteRegister, WriteData);
    end
    step();
    checks++;
    if ({RegWrite, PendingMask} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL tie_d3 got %0b/%h want 0/0", RegWrite, PendingMask);
    end
  endtask

  task automatic test_same_dest();
    // A fresh reset puts the priority state back on Load.
    Reset = 1'b1; #2; Reset = 1'b0;
    LoadValid = 1'b1; LoadRegister = 5'd9; LoadData = 32'h3F800000;
    AluValid  = 1'b1; AluRegister  = 5'd9; AluData  = 32'h40000000;
    step();
    LoadValid = 1'b0; AluValid = 1'b0;
    checks++;
    if (PendingMask !== 32'h200) begin
      errors++; $display("FAIL same_e1 got %h want 00000200", PendingMask);
    end
    step();
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd9, 32'h3F800000}) begin
      errors++; $display("FAIL same_w1 got %0b/%0d/%h want 1/9/3f800000", RegWrite, WriteRegister, WriteData);
    end
    step();
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd9, 32'h40000000}) begin
      errors++; $display("FAIL same_w2 got %0b/%0d/%h want 1/9/40000000", RegWrite, WriteRegister, WriteData);
    end
    step();
    checks++;
    if ({RegWrite, WriteData, PendingMask} !== {1'b0, 32'h40000000, 32'h0}) begin
      errors++; $display("FAIL same_end got %0b/%h/%h want 0/40000000/0", RegWrite, WriteData, PendingMask);
    end
  endtask

  task automatic test_reset_mid();
    LoadValid = 1'b1; LoadRegister = 5'd3; LoadData = 32'hAAAA0003;
    AluValid  = 1'b1; AluRegister  = 5'd7; AluData  = 32'hBBBB0007;
    step();
    LoadValid = 1'b0; AluValid = 1'b0;
    step();
    checks++;
    if ({RegWrite, PendingMask} !== {1'b1, 32'h88}) begin
      errors++; $display("FAIL rmid_pre got %0b/%h want 1/00000088", RegWrite, PendingMask);
    end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({RegWrite, PendingMask, WriteData, WriteRegister, AluReady, LoadReady} !== {1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL rmid_async got %0b/%h/%h/%0d/%0b/%0b want 0/0/0/0/1/1", RegWrite, PendingMask, WriteData, WriteRegister, AluReady, LoadReady);
    end
    #1 Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({RegWrite, PendingMask} !== {1'b0, 32'h0}) begin
        errors++; $display("FAIL rmid_idle%0d got %0b/%h want 0/0", i, RegWrite, PendingMask);
      end
    end
  endtask

  task automatic test_after_reset();
    // The very first edge after reset release must accept an entry.
    Reset = 1'b1; #1;
    AluValid = 1'b1; AluRegister = 5'd4; AluData = 32'hC0000000;
    #1 Reset = 1'b0;
    step();
    AluValid = 1'b0;
    checks++;
    if (PendingMask !== 32'h10) begin
      errors++; $display("FAIL post_rst_accept got %h want 00000010", PendingMask);
    end
    step();
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd4, 32'hC0000000}) begin
      errors++; $display("FAIL post_rst_write got %0b/%0d/%h want 1/4/c0000000", RegWrite, WriteRegister, WriteData);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    AluValid = 1'b0; AluRegister = 5'd0; AluData = 32'd0;
    LoadValid = 1'b0; LoadRegister = 5'd0; LoadData = 32'd0;
    test_reset();
    test_single_alu();
    test_reg0();
    test_tie();
    test_same_dest();
    test_reset_mid();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
